// File: rtl/arb_client_if.sv
// Requester-side bundle between arb_client and its environment:
// local token pushes plus the req/gnt handshake toward the round-robin arbiter.
interface arb_client_if #(
  parameter int N = 4
) ();
  logic [N-1:0] push;
  logic [N-1:0] full;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] own;
  logic [N-1:0] done;
  logic         err;

  modport master (
    input  push,
    input  gnt,
    output full,
    output req,
    output own,
    output done,
    output err
  );

  modport slave (
    output push,
    output gnt,
    input  full,
    input  req,
    input  own,
    input  done,
    input  err
  );
endinterface

// File: rtl/arb_client.sv
// Requester front end: per-channel token counters, req generation, grant accept and a
// fixed-length ownership burst. Optional protocol checker enabled by ARB_CLIENT_CHK_EN.
module arb_client #(
  parameter int N     = 4,
  parameter int CW    = 4,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  arb_client_if.master  bus
);

  localparam int            OW         = (N > 1) ? $clog2(N) : 1;
  localparam int            BW         = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
  localparam logic [BW-1:0] BURST_ZERO = {BW{1'b0}};
  localparam logic [N-1:0]  VEC_ZERO   = {N{1'b0}};
  localparam logic [N-1:0]  VEC_ONE    = N'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] owner;
  logic [OW-1:0] owner_nxt;
  logic [BW-1:0] burst;
  logic [BW-1:0] burst_nxt;
  logic [CW-1:0] cnt     [N];
  logic [CW-1:0] cnt_nxt [N];

  logic [N-1:0]  pend;
  logic [N-1:0]  full;
  logic [N-1:0]  qual;
  logic [N-1:0]  inc;
  logic [N-1:0]  dec;
  logic [N-1:0]  req;
  logic [N-1:0]  own;
  logic [N-1:0]  done;
  logic          accept;
  logic [OW-1:0] sel;
  logic          err;

  // Counter status decodes and lowest-index grant selection.
  always_comb begin
    pend   = VEC_ZERO;
    full   = VEC_ZERO;
    accept = 1'b0;
    sel    = {OW{1'b0}};
    for (int i = 0; i < N; i++) begin
      pend[i] = (cnt[i] != CNT_ZERO);
      full[i] = (cnt[i] == CNT_MAX);
    end
    // Only grants matching our own request are qualifying; gnt is ignored in OWN.
    qual = (state == IDLE) ? (bus.gnt & pend) : VEC_ZERO;
    for (int i = N - 1; i >= 0; i--) begin
      accept = accept | qual[i];
      sel    = qual[i] ? OW'(i) : sel;
    end
  end

  // Next pending count per channel; a push into a full counter is always dropped.
  always_comb begin
    inc = VEC_ZERO;
    dec = VEC_ZERO;
    for (int i = 0; i < N; i++) begin
      inc[i] = bus.push[i] & ~full[i];
      dec[i] = accept & (sel == OW'(i));
      case ({inc[i], dec[i]})
        2'b10:   cnt_nxt[i] = cnt[i] + CNT_ONE;
        2'b01:   cnt_nxt[i] = cnt[i] - CNT_ONE;
        default: cnt_nxt[i] = cnt[i];
      endcase
    end
  end

  // Pending token counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // FSM next state, owner/burst load and output decodes.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    burst_nxt = burst;
    req       = VEC_ZERO;
    own       = VEC_ZERO;
    done      = VEC_ZERO;
    case (state)
      IDLE: begin
        req = pend;
        if (accept) begin
          state_nxt = OWN;
          owner_nxt = sel;
          burst_nxt = BURST_LAST;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        own = VEC_ONE << owner;
        if (burst == BURST_ZERO) begin
          done      = VEC_ONE << owner;
          state_nxt = IDLE;
        end else begin
          burst_nxt = burst - BW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, owner and burst registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= {OW{1'b0}};
      burst <= BURST_ZERO;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      burst <= burst_nxt;
    end
  end

`ifdef ARB_CLIENT_CHK_EN
  logic gnt_bad;

  // Multi-hot grants, or grants to channels we are not requesting, are protocol errors.
  assign gnt_bad = (state == IDLE) &&
                   (((bus.gnt & (bus.gnt - VEC_ONE)) != VEC_ZERO) ||
                    ((bus.gnt & ~req) != VEC_ZERO));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (gnt_bad) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign bus.full = full;
  assign bus.req  = req;
  assign bus.own  = own;
  assign bus.done = done;
  assign bus.err  = err;

endmodule
